// File: rtl/transaction_dispatcher.sv
// Pops the granted queue head and issues it as one memory request, then pulses consumed; tracks in-flight and per-queue completions.
// Latency: pop/m_valid one cycle after grant, consumed the cycle after the handshake; m_ready low stalls ISSUE with fields held.
module transaction_dispatcher #(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int ADDRESS_WIDTH    = 40,
  parameter int LENGTH_WIDTH     = 8,
  parameter int MAX_OUTSTANDING  = 4,
  parameter int REGISTER_SIZE    = 32
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic [$clog2(NUMBER_OF_QUEUES)-1:0]       id,
  input  logic                                      valid_and_ready,
  output logic                                      ready,
  output logic                                      consumed,
  output logic [NUMBER_OF_QUEUES-1:0]               pop,
  input  logic [NUMBER_OF_QUEUES*ADDRESS_WIDTH-1:0] queue_addr,
  input  logic [NUMBER_OF_QUEUES*LENGTH_WIDTH-1:0]  queue_len,
  input  logic [NUMBER_OF_QUEUES-1:0]               queue_write,
  output logic                                      m_valid,
  input  logic                                      m_ready,
  output logic [ADDRESS_WIDTH-1:0]                  m_addr,
  output logic [LENGTH_WIDTH-1:0]                   m_len,
  output logic                                      m_write,
  output logic [$clog2(NUMBER_OF_QUEUES)-1:0]       m_id,
  input  logic                                      resp_valid,
  input  logic [$clog2(NUMBER_OF_QUEUES)-1:0]       resp_id,
  output logic                                      resp_ready,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]      outstanding,
  output logic [NUMBER_OF_QUEUES*REGISTER_SIZE-1:0] served,
  output logic                                      error
);

  localparam int NQ    = NUMBER_OF_QUEUES;
  localparam int AW    = ADDRESS_WIDTH;
  localparam int LW    = LENGTH_WIDTH;
  localparam int RS    = REGISTER_SIZE;
  localparam int ID_W  = $clog2(NUMBER_OF_QUEUES);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, ISSUE, CONSUME} state_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [AW-1:0]   addr;
    logic [LW-1:0]   len;
    logic            write;
  } req_t;

  state_t          state;
  req_t            req;
  logic [RS-1:0]   served_q [NQ];
  logic            handshake;
  logic            retire;

  // Derived only from registered state so the scheduler sees no path back from its own grant.
  assign ready      = (state == IDLE) && (outstanding < MAX_OUT);
  assign resp_ready = 1'b1;
  assign handshake  = m_valid && m_ready;
  assign retire     = resp_valid && (outstanding != '0);

  assign m_addr  = req.addr;
  assign m_len   = req.len;
  assign m_write = req.write;
  assign m_id    = req.id;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      req      <= '0;
      m_valid  <= 1'b0;
      pop      <= '0;
      consumed <= 1'b0;
    end else begin
      pop      <= '0;
      consumed <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_and_ready && ready) begin
            req.id    <= id;
            req.addr  <= queue_addr[id*AW +: AW];
            req.len   <= queue_len[id*LW +: LW];
            req.write <= queue_write[id];
            pop       <= NQ'(1) << id;
            m_valid   <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (m_ready) begin
            m_valid  <= 1'b0;
            consumed <= 1'b1;
            state    <= CONSUME;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A response with nothing in flight is flagged but still counted against its queue.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
      error       <= 1'b0;
    end else begin
      if (handshake && !retire)
        outstanding <= outstanding + OUT_W'(1);
      else if (!handshake && retire)
        outstanding <= outstanding - OUT_W'(1);
      if (resp_valid && (outstanding == '0))
        error <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NQ; i++) served_q[i] <= '0;
    end else begin
      for (int i = 0; i < NQ; i++)
        if (resp_valid && (resp_id == ID_W'(i)))
          served_q[i] <= served_q[i] + RS'(1);
    end
  end

  always_comb begin
    served = '0;
    for (int i = 0; i < NQ; i++) served[i*RS +: RS] = served_q[i];
  end

endmodule

// File: doc/transaction_dispatcher.md
# transaction_dispatcher

Downstream stage of the MemorEDF scheduler. It accepts the queue index granted by the scheduler, pops that queue's head descriptor, and issues it as one transaction on the memory-side request channel. It then generates the `consumed` pulse that drives the MemGuard and Aging budget updates. It also tracks in-flight transactions and keeps per-queue completion counters.

## Interface
- `NUMBER_OF_QUEUES`, 4, number of input queues (≥2)
- `ADDRESS_WIDTH`, 40, descriptor address width
- `LENGTH_WIDTH`, 8, descriptor burst length width
- `MAX_OUTSTANDING`, 4, maximum in-flight transactions (≥1)
- `REGISTER_SIZE`, 32, completion counter width

Ports:
- `clock`  in  1  single clock domain
- `reset`  in  1  asynchronous, active-high; clears all state
- `id`  in  $clog2(NUMBER_OF_QUEUES)  queue selected by the scheduler
- `valid_and_ready`  in  1  scheduler grant, already qualified by `ready`
- `ready`  out  1  dispatcher can accept a grant
- `consumed`  out  1  one-cycle pulse per issued transaction
- `pop`  out  NUMBER_OF_QUEUES  one-hot dequeue strobe
- `queue_addr`  in  NUMBER_OF_QUEUES×ADDRESS_WIDTH  head address per queue
- `queue_len`  in  NUMBER_OF_QUEUES×LENGTH_WIDTH  head length per queue
- `queue_write`  in  NUMBER_OF_QUEUES  head direction per queue (1 = write)
- `m_valid`  out  1  request valid
- `m_ready`  in  1  request accepted
- `m_addr`  out  ADDRESS_WIDTH  request address
- `m_len`  out  LENGTH_WIDTH  request length
- `m_write`  out  1  request direction
- `m_id`  out  $clog2(NUMBER_OF_QUEUES)  originating queue
- `resp_valid`  in  1  completion strobe
- `resp_id`  in  $clog2(NUMBER_OF_QUEUES)  queue of the completion
- `resp_ready`  out  1  constant 1
- `outstanding`  out  $clog2(MAX_OUTSTANDING+1)  in-flight count
- `served`  out  NUMBER_OF_QUEUES×REGISTER_SIZE  completions per queue
- `error`  out  1  sticky flag: spurious response

## Operation
- FSM has three states: IDLE, ISSUE, CONSUME. Reset state is IDLE.
- `ready` = (state == IDLE) && (outstanding < MAX_OUTSTANDING).
  - It is registered-state only and has no combinational path from `valid_and_ready` (avoids a loop through the scheduler).
- IDLE → ISSUE on `valid_and_ready`. At that edge:
  - latch `id`, `queue_addr[id]`, `queue_len[id]`, `queue_write[id]` into the request registers;
  - set `pop[id]` for exactly the next cycle.
- ISSUE:
  - `m_valid` = 1, and the `m_*` fields are held stable;
  - on `m_valid && m_ready`, increment `outstanding` and go to CONSUME.
- CONSUME: `consumed` = 1 for this single cycle, then go to IDLE.
  - This guarantees at least one low cycle between `consumed` pulses, which the scheduler needs for its rising-edge detect.
- `valid_and_ready` is ignored outside IDLE.
- Outstanding counter:
  - +1 on request handshake, −1 on `resp_valid`;
  - both in the same cycle leaves it unchanged;
  - it never exceeds MAX_OUTSTANDING because `ready` gates grants.
- Response handling:
  - `resp_valid` with `outstanding` == 0: no decrement, `error` set and held until reset; `served` is still updated.
  - `served[resp_id]` increments on every `resp_valid` and wraps modulo 2^REGISTER_SIZE.
- Reset values: `ready` = 1, `consumed` = 0, `pop` = 0, `m_valid` = 0, all `m_*` fields = 0, `outstanding` = 0, `served` = 0, `error` = 0, `resp_ready` = 1.

## Timing
- Grant accepted at edge T:
  - `pop` one-hot high during cycle T+1;
  - `m_valid` high from T+1.
- With `m_ready` = 1 at T+1: `consumed` high during T+2, `ready` high again at T+3.
- Peak throughput is one transaction per 3 cycles.
- Backpressure of N cycles delays `consumed` and `ready` by N. `pop` is unaffected and fires once per grant.
- `outstanding` updates on the edge of the handshake or response; `ready` reflects it the same cycle (IDLE state permitting).
- `reset` is asynchronous: mid-ISSUE it drops `m_valid` and `pop` immediately, without completing the handshake. Release is synchronous to `clock`.

## Test plan
- Reset, then release → `ready` = 1, `consumed` = 0, `pop` = 0, `m_valid` = 0, `outstanding` = 0, `error` = 0.
- Single grant: `id` = 2, `queue_addr[2]` = 0x1000, `queue_len[2]` = 3, `queue_write[2]` = 1, `m_ready` = 1, grant at T → `pop` = 4'b0100 at T+1 only; `m_addr` = 0x1000, `m_len` = 3, `m_write` = 1, `m_id` = 2 at T+1; `consumed` at T+2; `ready` at T+3; `outstanding` = 1.
- Backpressure: `m_ready` low for 5 cycles after the grant → `m_*` fields stable for 6 cycles, single `pop` pulse, `consumed` 1 cycle after the handshake, `ready` low throughout.
- Saturation: 4 grants with no responses → `outstanding` = 4 and `ready` stays 0. One `resp_valid` with `resp_id` = 1 → `outstanding` = 3, `served[1]` = 1, `ready` = 1 in the next cycle.
- Simultaneous handshake and response with `outstanding` = 2 → `outstanding` stays 2, `served[resp_id]` +1.
- Spurious `resp_valid` at `outstanding` = 0 → `error` = 1 and held, `outstanding` = 0. Assert `reset` mid-ISSUE → `m_valid` drops asynchronously and all outputs return to reset values.
